// File: rtl/fifo_serializer_pkg.sv
// Shared types and constants for the FIFO-to-serial-line transmitter.
package fifo_serializer_pkg;

  // Transmitter frame phases; the encoding is fixed so it can be probed
  // directly when debugging.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Level the serial line rests at between frames and during the stop bit.
  localparam logic LINE_IDLE = 1'b1;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// Cycles-per-bit counter. tick marks the final clock cycle of the current
// serial bit; the counter restarts whenever a new frame is loaded.
module bit_timer
  import fifo_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cyc;

  // With BIT_CYCLES=1 the counter is stuck at 0 and every cycle is a tick.
  assign tick = (cyc == LAST);

  // Count cycles within a bit: hold at 0 when idle or loading, wrap on tick.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= '0;
    end else if (load || !run || tick) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serializer.sv
// Drains words from the FIFO head and sends each as a UART-style frame:
// start bit 0, WIDTH data bits LSB first, stop bit 1. The line idles high.
module fifo_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int BIT_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_out,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shifted;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_next;
  logic             tx_next;
  logic [CNT_W-1:0] count_next;
  logic             take;
  logic             tick;

  // A new word may be accepted only when allowed, available and not in reset;
  // the reset term keeps fifo_pop low for the whole time reset is asserted.
  assign take    = enable & ~fifo_empty & ~reset;
  assign busy    = (state != IDLE);
  assign shifted = shreg >> 1;

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .load  (fifo_pop),
    .run   (busy),
    .tick  (tick)
  );

  // Next-state, datapath next values and the combinational pop request.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = idx;
    tx_next    = tx;
    count_next = frame_count;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          fifo_pop   = 1'b1;
          shreg_next = fifo_out;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          tx_next    = shreg[0];
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = shifted;
          if (idx == LAST_BIT) begin
            tx_next    = LINE_IDLE;
            state_next = STOP;
          end else begin
            idx_next = idx + 1'b1;
            tx_next  = shifted[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          count_next = frame_count + 1'b1;
          if (take) begin
            // Back-to-back handoff: the next start bit follows immediately.
            fifo_pop   = 1'b1;
            shreg_next = fifo_out;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = LINE_IDLE;
            state_next = IDLE;
          end
        end
      end
      default: begin
        tx_next    = LINE_IDLE;
        state_next = IDLE;
      end
    endcase
  end

  // State, shift register, bit index, registered line and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      idx         <= '0;
      tx          <= LINE_IDLE;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      idx         <= idx_next;
      tx          <= tx_next;
      frame_count <= count_next;
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: two instances (1 and 3 cycles per bit) each fed
// by a bench-side FIFO, checked every cycle against a frame-position model,
// plus hand-computed waveform checks for the directed scenarios.
module tb_fifo_serializer;

  localparam int W = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic chk_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side FIFO storage; tail written by stimulus, head by each lane.
  logic [W-1:0] mem [2][DEPTH];
  int           tail [2];

  // Per-lane DUT outputs gathered for the directed checks.
  logic       tx_a   [2];
  logic       busy_a [2];
  logic       pop_a  [2];
  logic [7:0] fc_a   [2];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int B  = (g == 0) ? 1 : 3;
    localparam int CW = (g == 0) ? 8 : 3;
    localparam int L  = (W + 2) * B;

    logic          tx, busy, pop, fifo_empty;
    logic [W-1:0]  fifo_out;
    logic [CW-1:0] fcw;
    int            head = 0;

    // Model: pos is the cycle offset inside the current frame, -1 when idle.
    int            pos = -1;
    int            fc = 0;
    logic [W-1:0]  word = '0;
    logic          m_pop_l = 1'b0;
    logic          d_pop_l = 1'b0;

    assign fifo_empty = (head == tail[g]);
    assign fifo_out   = mem[g][head % DEPTH];
    assign tx_a[g]    = tx;
    assign busy_a[g]  = busy;
    assign pop_a[g]   = pop;
    assign fc_a[g]    = 8'(fcw);

    fifo_serializer #(
      .WIDTH      (W),
      .BIT_CYCLES (B),
      .CNT_W      (CW)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .fifo_out    (fifo_out),
      .fifo_empty  (fifo_empty),
      .fifo_pop    (pop),
      .tx          (tx),
      .busy        (busy),
      .frame_count (fcw)
    );

    // Compare DUT outputs with the model mid-cycle, then latch pop decisions.
    always @(negedge clk) begin
      int   bi;
      logic e_tx, e_take, e_pop;
      e_take = enable && !fifo_empty && !reset;
      e_pop  = e_take && (pos < 0 || pos == L - 1);
      bi     = (pos < 0) ? 0 : pos / B;
      if (pos < 0)       e_tx = 1'b1;
      else if (bi == 0)  e_tx = 1'b0;
      else if (bi <= W)  e_tx = word[bi-1];
      else               e_tx = 1'b1;
      if (chk_on) begin
        check($sformatf("lane%0d tx", g), 32'(tx), 32'(e_tx));
        check($sformatf("lane%0d busy", g), 32'(busy), 32'(pos >= 0));
        check($sformatf("lane%0d pop", g), 32'(pop), 32'(e_pop));
        check($sformatf("lane%0d frame_count", g), 32'(fcw), 32'(fc));
      end
      m_pop_l <= e_pop;
      d_pop_l <= pop;
    end

    // Advance the model one clock; the FIFO drops its head on a DUT pop.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        pos <= -1;
        fc  <= 0;
      end else begin
        if (pos == L - 1) fc <= (fc + 1) % (1 << CW);
        if (m_pop_l) begin
          word <= mem[g][head % DEPTH];
          pos  <= 0;
        end else if (pos >= 0 && pos < L - 1) begin
          pos <= pos + 1;
        end else begin
          pos <= -1;
        end
        if (d_pop_l && head != tail[g]) head <= head + 1;
      end
    end
  end

  task automatic push(input int ln, input logic [W-1:0] w);
    mem[ln][tail[ln] % DEPTH] = w;
    tail[ln]++;
  endtask

  function automatic int occ(input int ln);
    return (ln == 0) ? tail[0] - lane[0].head : tail[1] - lane[1].head;
  endfunction

  logic e3 [8];
  logic e2 [4];
  bit   done;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    tail[0] = 0;
    tail[1] = 0;
    e2 = '{1'b0, 1'b1, 1'b0, 1'b1};
    e3 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    check("reset tx", 32'(tx_a[0]), 32'd1);
    check("reset fc", 32'(fc_a[0]), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    enable = 1'b1;

    // Empty FIFO: the block must stay idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle pop", 32'(pop_a[0]), 32'd0);
      check("idle tx", 32'(tx_a[0]), 32'd1);
      check("idle busy", 32'(busy_a[0]), 32'd0);
    end

    // Single word 01.
    @(posedge clk); #1;
    push(0, 2'b01);
    @(negedge clk);
    check("t2 pop", 32'(pop_a[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2 tx", 32'(tx_a[0]), 32'(e2[k]));
      check("t2 busy", 32'(busy_a[0]), 32'd1);
    end
    @(negedge clk);
    check("t2 tx after", 32'(tx_a[0]), 32'd1);
    check("t2 busy after", 32'(busy_a[0]), 32'd0);
    check("t2 fc", 32'(fc_a[0]), 32'd1);

    // Back-to-back 11 then 10.
    @(posedge clk); #1;
    push(0, 2'b11);
    push(0, 2'b10);
    @(negedge clk);
    check("t3 pop first", 32'(pop_a[0]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3 tx", 32'(tx_a[0]), 32'(e3[k]));
      check("t3 busy", 32'(busy_a[0]), 32'd1);
      if (k == 3) check("t3 pop handoff", 32'(pop_a[0]), 32'd1);
    end
    @(negedge clk);
    check("t3 busy after", 32'(busy_a[0]), 32'd0);
    check("t3 fc", 32'(fc_a[0]), 32'd3);

    // Three cycles per bit, word 10.
    @(posedge clk); #1;
    push(1, 2'b10);
    @(negedge clk);
    check("t4 pop", 32'(pop_a[1]), 32'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t4 tx", 32'(tx_a[1]), (k < 6) ? 32'd0 : 32'd1);
      check("t4 busy", 32'(busy_a[1]), 32'd1);
    end
    @(negedge clk);
    check("t4 busy after", 32'(busy_a[1]), 32'd0);
    check("t4 fc", 32'(fc_a[1]), 32'd1);

    // enable falls during DATA with the FIFO still holding a word.
    @(posedge clk); #1;
    push(0, 2'b11);
    push(0, 2'b00);
    @(negedge clk);
    check("t5 pop", 32'(pop_a[0]), 32'd1);
    @(negedge clk);
    check("t5 start", 32'(tx_a[0]), 32'd0);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5 tx", 32'(tx_a[0]), 32'd1);
      check("t5 no pop", 32'(pop_a[0]), 32'd0);
    end
    @(negedge clk);
    check("t5 busy after", 32'(busy_a[0]), 32'd0);
    check("t5 fc", 32'(fc_a[0]), 32'd4);

    // Reset during START of word 00.
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check("t6 pop", 32'(pop_a[0]), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("t6 async tx", 32'(tx_a[0]), 32'd1);
    check("t6 async busy", 32'(busy_a[0]), 32'd0);
    check("t6 async fc", 32'(fc_a[0]), 32'd0);
    check("t6 async pop", 32'(pop_a[0]), 32'd0);
    @(posedge clk); #1;
    push(0, 2'b10);
    @(negedge clk);
    check("t6 pop in reset", 32'(pop_a[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6 pop after release", 32'(pop_a[0]), 32'd1);
    @(negedge clk);
    check("t6 start after release", 32'(tx_a[0]), 32'd0);

    // Random traffic, enable toggling and one mid-run reset pulse.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == 150) begin
        #1 reset = 1'b1;
      end else if (c == 151) begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) enable = ($urandom_range(0, 4) != 0);
      for (int ln = 0; ln < 2; ln++)
        if (occ(ln) < DEPTH - 4 && $urandom_range(0, 2) == 0)
          push(ln, W'($urandom));
    end

    // Drain everything with a bounded wait.
    @(posedge clk); #1;
    enable = 1'b1;
    done   = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (occ(0) == 0 && occ(1) == 0 && lane[0].pos < 0 && lane[1].pos < 0) done = 1'b1;
    end
    check("drain complete", 32'(done), 32'd1);
    @(negedge clk);
    check("final tx0", 32'(tx_a[0]), 32'd1);
    check("final tx1", 32'(tx_a[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Read-side companion to the team's push/pop FIFO.
- Drains words from the FIFO head and transmits each as a UART-style serial frame: start bit 0, WIDTH data bits LSB first, stop bit 1.
- The line idles high.
- Sits between the FIFO read port and a single-wire serial output.

Parameters:
- WIDTH, 2, data word width; must match the FIFO word width.
- BIT_CYCLES, 1, clock cycles per serial bit (>=1).
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting new frames; does not abort a frame in flight.
- fifo_out  input  WIDTH  FIFO head word (oldest entry); valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO holds no entries.
- fifo_pop  output  1  pop request to FIFO; the FIFO removes its head on the posedge where this is 1.
- tx  output  1  serial line, registered.
- busy  output  1  frame in progress (state != IDLE).
- frame_count  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, tx=1, busy=0, frame_count=0, bit/cycle counters=0, shift register=0.
  - fifo_pop is forced to 0 while reset is high.
- States: IDLE, START, DATA, STOP.
- Cycle counter cyc runs 0..BIT_CYCLES-1 within each bit; bit index idx runs 0..WIDTH-1 in DATA.
- take = enable & ~fifo_empty & ~reset. take is evaluated in IDLE, and in STOP only when cyc==BIT_CYCLES-1.
- fifo_pop = take in those two cases, else 0. It is combinational and single-cycle per frame.
- On a posedge with take=1: shreg<=fifo_out, tx<=0, state<=START, cyc<=0.
- START: hold tx=0 for BIT_CYCLES cycles. At the last cycle: tx<=shreg[0], state<=DATA, idx<=0.
- DATA: hold each bit BIT_CYCLES cycles.
  - At the end of each bit: shreg shifts right and idx increments; tx<=the next bit.
  - After bit WIDTH-1: tx<=1, state<=STOP.
- STOP: hold tx=1 for BIT_CYCLES cycles. At the last cycle: frame_count increments, then:
  - take=1: back-to-back frame (pop, load, tx<=0, state<=START).
  - otherwise: state<=IDLE, tx stays 1.
- Latency: the first start bit appears on tx the cycle after the pop edge.
- Frame length is exactly (WIDTH+2)*BIT_CYCLES cycles. Back-to-back frames have no idle gap.
- Boundary behaviour:
  - fifo_empty=1 in IDLE: no pop, tx=1, busy=0 indefinitely.
  - enable falls mid-frame: the current frame completes normally, then the block goes to IDLE.
  - fifo_empty rises mid-frame: no effect until the STOP decision point.
  - Reset mid-frame: the frame is aborted, tx=1 immediately, the word is lost, frame_count=0.
  - frame_count at 2^CNT_W-1 wraps to 0.
  - Words are never popped while busy except at the STOP-end handoff.
- busy is derived from the registered state: 1 in START/DATA/STOP.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the idle-line level constant (1'b1).
- The cycles-per-bit counter is naturally a small sub-module, bit_timer: load, tick-at-terminal output, parameter BIT_CYCLES.
- Everything else (FSM, shift register, frame counter) stays in fifo_serializer.

Test Plan:
1. After reset with fifo_empty=1, enable=1 for 10 cycles -> fifo_pop=0, tx=1, busy=0, frame_count=0 throughout.
2. WIDTH=2, BIT_CYCLES=1, single word 2'b01 at the head, fifo_empty falls -> one-cycle fifo_pop; tx over the next 4 cycles = 0,1,0,1; busy=1 for 4 cycles; frame_count=1; then tx=1, busy=0.
3. FIFO holding 2'b11 then 2'b10, enable=1 -> two pops exactly 4 cycles apart; tx = 0,1,1,1,0,0,1,1 with no idle gap; frame_count=2.
4. BIT_CYCLES=3, word 2'b10 -> tx = 0 for 3 cycles, 0 for 3, 1 for 3, 1 for 3; exactly one pop; frame length 12 cycles.
5. Word 2'b11 in flight; drop enable during the DATA state, FIFO still non-empty -> frame completes (tx 0,1,1,1); no further pop; busy=0 afterwards.
6. Assert reset during the START state of word 2'b00 -> tx=1 and busy=0 immediately (asynchronous, before the next edge); frame_count=0; fifo_pop=0 while reset is high. After release with data available, the next pop occurs on the first edge.
